par2ser_tx: RTL and testbench

PAR2SER_TX -- requirements
Module: par2ser_tx

---
 rtl/par2ser_pkg.sv | 11 +
 rtl/par2ser_tx_hold.sv | 28 ++
 rtl/par2ser_tx.sv | 103 ++++++++++
 tb/tb_par2ser_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared state encoding and idle line level for the parallel-to-serial transmitter.
package par2ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_LVL = 1'b1;

endpackage

// File: rtl/par2ser_tx_hold.sv
// One-word load/clear holding register with a full flag.
// Latency: q/full update on the edge after ld or cl; ld wins over cl.
// Backpressure: none here; the owner gates ld on !full.
module p2s_hold_reg #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         ld,
    input  logic         cl,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         full
);

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            q    <= '0;
            full <= 1'b0;
        end else if (ld) begin
            q    <= d;
            full <= 1'b1;
        end else if (cl) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/par2ser_tx.sv
// N-bit parallel word to MSB-first serial stream, DIV clocks per bit (PAR2SER_TX_DBUF_EN adds a pending word).
// Latency: MSB on sdo from the accepting edge; frame ends N*DIV edges later with a done pulse.
// Backpressure: ready=0 while shifting, or with PAR2SER_TX_DBUF_EN while the pending word is occupied.
module par2ser_tx
    import par2ser_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] inData,
    output logic         ready,
    output logic         busy,
    output logic         sdo,
    output logic         bitStrobe,
    output logic         done
);

    localparam int BW = (N > 2) ? $clog2(N) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_TOP = BW'(N - 1);
    localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

    state_t         state;
    logic [N-1:0]   shreg;
    logic [BW-1:0]  bitcnt;
    logic [DW-1:0]  divcnt;

    logic           accept;
    logic           frame_end;
    logic           start_vld;
    logic [N-1:0]   start_dat;

    assign accept    = load && ready;
    assign frame_end = (state == SHIFT) && (bitcnt == '0) && (divcnt == '0);

`ifdef PAR2SER_TX_DBUF_EN
    logic           pend_vld;
    logic [N-1:0]   pend_dat;

    // Words arriving mid-frame park here; a word on the frame-end edge goes straight to the shifter.
    p2s_hold_reg #(.N(N)) u_hold (
        .clock (clock),
        .clr   (clr),
        .ld    (accept && (state == SHIFT) && !frame_end),
        .cl    (frame_end && pend_vld),
        .d     (inData),
        .q     (pend_dat),
        .full  (pend_vld)
    );

    assign ready     = !pend_vld;
    assign start_vld = (frame_end && pend_vld) || (accept && ((state == IDLE) || frame_end));
    assign start_dat = pend_vld ? pend_dat : inData;
`else
    assign ready     = (state == IDLE);
    assign start_vld = accept;
    assign start_dat = inData;
`endif

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            divcnt    <= '0;
            sdo       <= IDLE_LVL;
            busy      <= 1'b0;
            bitStrobe <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= frame_end;
            bitStrobe <= 1'b0;
            if (start_vld) begin
                // Back-to-back start takes priority over returning to idle, so busy never drops.
                state     <= SHIFT;
                shreg     <= start_dat;
                sdo       <= start_dat[N-1];
                bitcnt    <= BIT_TOP;
                divcnt    <= DIV_TOP;
                busy      <= 1'b1;
                bitStrobe <= 1'b1;
            end else if (frame_end) begin
                state <= IDLE;
                sdo   <= IDLE_LVL;
                busy  <= 1'b0;
            end else if (state == SHIFT) begin
                if (divcnt != '0) begin
                    divcnt <= divcnt - 1'b1;
                end else begin
                    divcnt    <= DIV_TOP;
                    bitcnt    <= bitcnt - 1'b1;
                    shreg     <= shreg << 1;
                    sdo       <= shreg[N-2];
                    bitStrobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: DIV=4 and DIV=1 instances share stimulus; a timeline model predicts every output each cycle.
module tb_par2ser_tx;

    localparam int N = 8;
`ifdef PAR2SER_TX_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         clr;
    logic         load;
    logic [N-1:0] in_data;
    logic [1:0]   ready, busy, sdo, bit_strobe, done;

    always #5 clock = ~clock;

    par2ser_tx #(.N(N), .DIV(4)) u_div4 (
        .clock(clock), .clr(clr), .load(load), .inData(in_data),
        .ready(ready[0]), .busy(busy[0]), .sdo(sdo[0]),
        .bitStrobe(bit_strobe[0]), .done(done[0])
    );

    par2ser_tx #(.N(N), .DIV(1)) u_div1 (
        .clock(clock), .clr(clr), .load(load), .inData(in_data),
        .ready(ready[1]), .busy(busy[1]), .sdo(sdo[1]),
        .bitStrobe(bit_strobe[1]), .done(done[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a frame is just (start edge, word); everything else follows from elapsed time.
    bit           act [2];
    bit           pv  [2];
    bit           dn  [2];
    int           st  [2];
    logic [N-1:0] wd  [2];
    logic [N-1:0] pw  [2];

    function automatic int div_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            pv[i]  = 1'b0;
            dn[i]  = 1'b0;
            st[i]  = 0;
            wd[i]  = '0;
            pw[i]  = '0;
        end
    endtask

    task automatic model_edge(int i);
        bit rdy, acc, fe;
        rdy = DBUF ? !pv[i] : !act[i];
        acc = load && rdy;
        fe  = act[i] && ((cyc - st[i]) == N * div_of(i));
        dn[i] = fe;
        if (fe) act[i] = 1'b0;
        if (DBUF && fe && pv[i]) begin
            act[i] = 1'b1; st[i] = cyc; wd[i] = pw[i]; pv[i] = 1'b0;
        end else if (acc) begin
            if (!act[i]) begin
                act[i] = 1'b1; st[i] = cyc; wd[i] = in_data;
            end else begin
                pv[i] = 1'b1; pw[i] = in_data;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int   off;
            logic e_sdo, e_stb, e_rdy;
            off   = cyc - st[i];
            e_sdo = 1'b1;
            e_stb = 1'b0;
            if (act[i]) begin
                e_sdo = wd[i][N - 1 - off / div_of(i)];
                e_stb = ((off % div_of(i)) == 0);
            end
            e_rdy = DBUF ? !pv[i] : !act[i];
            chk($sformatf("sdo[%0d]", i),       sdo[i],        e_sdo);
            chk($sformatf("busy[%0d]", i),      busy[i],       act[i]);
            chk($sformatf("bitStrobe[%0d]", i), bit_strobe[i], e_stb);
            chk($sformatf("done[%0d]", i),      done[i],       dn[i]);
            chk($sformatf("ready[%0d]", i),     ready[i],      e_rdy);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        if (clr) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) model_edge(i);
        end
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            in_data = N'($urandom);
            tick();
        end
    endtask

    task automatic offer(logic [N-1:0] w);
        load    = 1'b1;
        in_data = w;
        tick();
        load    = 1'b0;
        in_data = N'($urandom);
    endtask

    // Async reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_clr();
        clr = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        clr = 1'b0;
    endtask

    initial begin
        clr     = 1'b1;
        load    = 1'b0;
        in_data = '0;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        clr = 1'b0;
        idle(2);

        offer(8'hA5); idle(40);
        offer(8'h3C); idle(40);
        offer(8'h00); idle(10); offer(8'hFF); idle(40);
        offer(8'h81); idle(10); offer(8'h7E); idle(45);
        offer(8'hC3); idle(13); do_clr(); idle(2);
        offer(8'h01); idle(40);

        for (int n = 0; n < 600; n++) begin
            load    = ($urandom_range(0, 3) == 0);
            in_data = N'($urandom);
            if ($urandom_range(0, 199) == 0) do_clr();
            else tick();
        end
        load = 1'b0;
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
